data_sram_like_responder: RTL

//  Responder end of the data_sram_* sram-like bus issued by the EX stage and completed in MEM.

---
 rtl/data_sram_like_responder.sv | 125 ++++++++++++
 1 files changed

// File: rtl/data_sram_like_responder.sv
// In-order sram-like data responder: accepts data_sram_* requests and answers each with data_ok after LATENCY cycles.
// Optional `DATA_SRAM_RAND_STALL_EN throttles addr_ok with a 16-bit LFSR to exercise the requester's wait path.
module data_sram_like_responder #(
  parameter int MEM_AW  = 12,
  parameter int LATENCY = 2,
  parameter int QDEPTH  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);
  localparam int TW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [CW-1:0] FULL   = CW'(QDEPTH);
  localparam logic [PW-1:0] LAST   = PW'(QDEPTH - 1);
  localparam logic [TW-1:0] T_LOAD = TW'(LATENCY - 1);

  logic [31:0]       mem     [2**MEM_AW];
  logic [31:0]       q_rdata [QDEPTH];
  logic [TW-1:0]     q_timer [QDEPTH];
  logic [QDEPTH-1:0] q_valid;
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [CW-1:0]     count;

  logic              room;
  logic              push;
  logic              pop;
  logic [MEM_AW-1:0] idx;

  // Size is informational and the byte offset is never checked.
  logic unused;
  assign unused = ^{data_sram_size, data_sram_addr};

`ifdef DATA_SRAM_RAND_STALL_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr <= 16'hACE1;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  assign room = (count < FULL) && (lfsr[1:0] != 2'b00);
`else
  assign room = (count < FULL);
`endif

  // Outputs are forced low during reset so no stale response escapes the reset cycle.
  assign data_sram_addr_ok = room & ~reset;
  assign push              = data_sram_req & data_sram_addr_ok;
  assign pop               = q_valid[head] && (q_timer[head] == '0) && !reset;
  assign idx               = data_sram_addr[MEM_AW+1:2];

  assign data_sram_data_ok = pop;
  assign data_sram_rdata   = pop ? q_rdata[head] : 32'h0;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      q_valid <= '0;
    end else begin
      if (pop) begin
        q_valid[head] <= 1'b0;
        head          <= (head == LAST) ? '0 : head + 1'b1;
      end
      if (push) begin
        q_valid[tail] <= 1'b1;
        tail          <= (tail == LAST) ? '0 : tail + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Timers of empty slots are don't-care; a push always reloads its slot.
  always_ff @(posedge clk) begin
    for (int i = 0; i < QDEPTH; i++) begin
      if (q_valid[i] && (q_timer[i] != '0)) begin
        q_timer[i] <= q_timer[i] - 1'b1;
      end
    end
    if (push) begin
      q_timer[tail] <= T_LOAD;
    end
  end

  // NOTE: the RAM and entry payloads have no reset; contents survive reset and
  // validity is tracked solely by q_valid.
  always_ff @(posedge clk) begin
    if (push) begin
      if (data_sram_wr) begin
        for (int b = 0; b < 4; b++) begin
          if (data_sram_wstrb[b]) begin
            mem[idx][8*b +: 8] <= data_sram_wdata[8*b +: 8];
          end
        end
        q_rdata[tail] <= 32'h0;
      end else begin
        q_rdata[tail] <= mem[idx];
      end
    end
  end

endmodule
